// File: rtl/md_pkg.sv
// Shared types and constants for the multiplier-divider issue/retire stage.
package md_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } md_state_e;

    typedef enum logic {
        OP_MULT = 1'b0,
        OP_DIV  = 1'b1
    } md_op_e;

    localparam logic [4:0]  MD_RSTATUS_REG   = 5'd30;
    localparam logic [31:0] MD_MULT_EXC_CODE = 32'd4;
    localparam logic [31:0] MD_DIV_EXC_CODE  = 32'd5;

    // $rstatus payload for a failed operation, chosen by the operation kind
    function automatic logic [31:0] exc_payload(input md_op_e op,
                                                input logic [31:0] mult_code,
                                                input logic [31:0] div_code);
        logic [31:0] code_v;
        case (op)
            OP_MULT: code_v = mult_code;
            OP_DIV:  code_v = div_code;
            default: code_v = mult_code;
        endcase
        return code_v;
    endfunction

endpackage

// File: rtl/md_busy_counter.sv
// Clearable, enabled up-counter that flags when it reaches TERMINAL.
module md_busy_counter #(
    parameter int COUNT_W  = 7,
    parameter int TERMINAL = 63
) (
    input  logic               clock,
    input  logic               ctrl_reset,
    input  logic               clr,
    input  logic               en,
    output logic [COUNT_W-1:0] count,
    output logic               tc
);

    logic [COUNT_W-1:0] count_q;
    logic [COUNT_W-1:0] count_d;

    // next count: clear has priority over increment
    always_comb begin
        if (clr) begin
            count_d = {COUNT_W{1'b0}};
        end else if (en) begin
            count_d = count_q + COUNT_W'(1);
        end else begin
            count_d = count_q;
        end
    end

    // count register with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            count_q <= {COUNT_W{1'b0}};
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign tc    = (count_q == COUNT_W'(TERMINAL));

endmodule

// File: rtl/md_issue_ctrl.sv
// Issue/retire control between execute and the multiplier-divider unit:
// launches one operation, stalls upstream while it runs, and hands the result to writeback.
module md_issue_ctrl
    import md_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 64,
    parameter int          COUNT_W        = 7,
    parameter logic [4:0]  RSTATUS_REG    = MD_RSTATUS_REG,
    parameter logic [31:0] MULT_EXC_CODE  = MD_MULT_EXC_CODE,
    parameter logic [31:0] DIV_EXC_CODE   = MD_DIV_EXC_CODE
) (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        req_mult,
    input  logic        req_div,
    input  logic [31:0] req_operandA,
    input  logic [31:0] req_operandB,
    input  logic [4:0]  req_rd,
    input  logic        ctrl_flush,
    output logic        md_ctrl_MULT,
    output logic        md_ctrl_DIV,
    output logic [31:0] md_operandA,
    output logic [31:0] md_operandB,
    input  logic [31:0] md_result,
    input  logic        md_exception,
    input  logic        md_resultRDY,
    output logic        stall_pipeline,
    output logic        wb_valid,
    input  logic        wb_ready,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        wb_exception
);

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic        ctrl_mult_q, ctrl_mult_d;
    logic        ctrl_div_q, ctrl_div_d;
    logic [4:0]  wb_rd_q, wb_rd_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic        wb_exc_q, wb_exc_d;

    logic               cnt_clr_s;
    logic               cnt_en_s;
    logic               cnt_tc_s;
    logic [COUNT_W-1:0] cnt_s;

    md_busy_counter #(
        .COUNT_W  (COUNT_W),
        .TERMINAL (TIMEOUT_CYCLES - 1)
    ) u_busy_counter (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .clr        (cnt_clr_s),
        .en         (cnt_en_s),
        .count      (cnt_s),
        .tc         (cnt_tc_s)
    );

    // next-state, operand latch and writeback capture
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        rd_d        = rd_q;
        opa_d       = opa_q;
        opb_d       = opb_q;
        ctrl_mult_d = 1'b0;
        ctrl_div_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_exc_d    = wb_exc_q;
        cnt_clr_s   = 1'b0;
        cnt_en_s    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req_mult || req_div) begin
                    op_d        = req_mult ? OP_MULT : OP_DIV;
                    rd_d        = req_rd;
                    opa_d       = req_operandA;
                    opb_d       = req_operandB;
                    // pulse registers are loaded now so they are high exactly during START
                    ctrl_mult_d = req_mult;
                    ctrl_div_d  = ~req_mult;
                    state_d     = START;
                end else begin
                    state_d = IDLE;
                end
            end
            START: begin
                cnt_clr_s = 1'b1;
                if (ctrl_flush) begin
                    state_d = IDLE;
                end else begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                cnt_en_s = 1'b1;
                if (ctrl_flush) begin
                    state_d = IDLE;
                end else if (md_resultRDY && (cnt_s != {COUNT_W{1'b0}})) begin
                    // a ready seen at count 0 may be left over from the previous op
                    if (md_exception) begin
                        wb_rd_d   = RSTATUS_REG;
                        wb_data_d = exc_payload(op_q, MULT_EXC_CODE, DIV_EXC_CODE);
                        wb_exc_d  = 1'b1;
                    end else begin
                        wb_rd_d   = rd_q;
                        wb_data_d = md_result;
                        wb_exc_d  = 1'b0;
                    end
                    state_d = DONE;
                end else if (cnt_tc_s) begin
                    wb_rd_d   = RSTATUS_REG;
                    wb_data_d = exc_payload(op_q, MULT_EXC_CODE, DIV_EXC_CODE);
                    wb_exc_d  = 1'b1;
                    state_d   = DONE;
                end else begin
                    state_d = BUSY;
                end
            end
            DONE: begin
                if (wb_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state and output registers with synchronous active-low reset
    always_ff @(posedge clock) begin
        if (!ctrl_reset) begin
            state_q     <= IDLE;
            op_q        <= OP_MULT;
            rd_q        <= 5'd0;
            opa_q       <= 32'd0;
            opb_q       <= 32'd0;
            ctrl_mult_q <= 1'b0;
            ctrl_div_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            wb_exc_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rd_q        <= rd_d;
            opa_q       <= opa_d;
            opb_q       <= opb_d;
            ctrl_mult_q <= ctrl_mult_d;
            ctrl_div_q  <= ctrl_div_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_exc_q    <= wb_exc_d;
        end
    end

    assign md_ctrl_MULT   = ctrl_mult_q;
    assign md_ctrl_DIV    = ctrl_div_q;
    assign md_operandA    = opa_q;
    assign md_operandB    = opb_q;
    assign wb_rd          = wb_rd_q;
    assign wb_data        = wb_data_q;
    assign wb_exception   = wb_exc_q;
    assign stall_pipeline = (state_q != IDLE);
    assign wb_valid       = (state_q == DONE);

endmodule
